execute_stage_m: RTL and testbench

- Parametrised next-generation execute stage. Keeps the single-cycle RV ALU/branch/jump datapath with 2-source forwarding, and adds:
  - XLEN generalisation;
  - the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative multi-cycle unit with a stall handshake;
  - an internal registered EX/MEM boundary.
- Sits between the ID/EX register and the memory stage. Drives the PC-redirect mux combinationally.

---
 rtl/rv_ex_pkg.sv | 43 ++++
 rtl/execute_stage_m_if.sv | 49 ++++
 rtl/muldiv_iter.sv | 144 ++++++++++++++
 rtl/execute_stage_m.sv | 206 ++++++++++++++++++++
 tb/tb_execute_stage_m.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ex_pkg.sv
// Shared encodings for the execute stage: operand/forward selects, ALU classes
// and ops, M-extension funct3 codes and the mul/div sequencer states.
package rv_ex_pkg;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // Upper funct3 bit separates divide/remainder from multiply.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/execute_stage_m_if.sv
// ID/EX inputs, forwarding inputs and EX/MEM + redirect outputs of the execute
// stage. master = pipeline/upstream side, slave = the execute stage itself.
interface execute_stage_m_if #(parameter int XLEN = 32);
  logic            ex_valid;
  logic            flush;
  logic            ex_RegWrite, ex_MemtoReg, ex_Branch, ex_Jump;
  logic            ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_muldiv;
  logic [1:0]      ex_op_a_sel;
  logic [1:0]      ex_ALUOp;
  logic [XLEN-1:0] ex_read_data_1, ex_read_data_2, ex_immediate, ex_pc_plus_4;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [1:0]      forward_a, forward_b;
  logic [XLEN-1:0] mem_alu_result, wb_alu_result;

  logic            ex_stall;
  logic            mem_valid_out, mem_RegWrite_out, mem_MemtoReg_out;
  logic            mem_MemWrite_out, mem_MemRead_out;
  logic [XLEN-1:0] mem_alu_result_out, mem_write_data_out;
  logic [4:0]      mem_rd_out;
  logic [2:0]      mem_funct3_out;
  logic [XLEN-1:0] branch_target_addr_out;
  logic            branch_taken_out;

  modport master (
    output ex_valid, flush, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_Jump,
           ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_muldiv, ex_op_a_sel, ex_ALUOp,
           ex_read_data_1, ex_read_data_2, ex_immediate, ex_pc_plus_4,
           ex_rd, ex_funct3, ex_funct7, forward_a, forward_b,
           mem_alu_result, wb_alu_result,
    input  ex_stall, mem_valid_out, mem_RegWrite_out, mem_MemtoReg_out,
           mem_MemWrite_out, mem_MemRead_out, mem_alu_result_out,
           mem_write_data_out, mem_rd_out, mem_funct3_out,
           branch_target_addr_out, branch_taken_out
  );

  modport slave (
    input  ex_valid, flush, ex_RegWrite, ex_MemtoReg, ex_Branch, ex_Jump,
           ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_muldiv, ex_op_a_sel, ex_ALUOp,
           ex_read_data_1, ex_read_data_2, ex_immediate, ex_pc_plus_4,
           ex_rd, ex_funct3, ex_funct7, forward_a, forward_b,
           mem_alu_result, wb_alu_result,
    output ex_stall, mem_valid_out, mem_RegWrite_out, mem_MemtoReg_out,
           mem_MemWrite_out, mem_MemRead_out, mem_alu_result_out,
           mem_write_data_out, mem_rd_out, mem_funct3_out,
           branch_target_addr_out, branch_taken_out
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative M-extension unit: XLEN-cycle shift-add multiply / restoring divide
// on magnitudes, with sign fix-up applied combinationally in the DONE state.
module muldiv_iter
  import rv_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  md_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, b_reg;
  logic [2:0]        op_reg;
  logic [4:0]        rd_reg;
  logic              a_neg_reg, b_neg_reg, b_zero_reg;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_fit;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      M_MUL, M_MULH, M_DIV, M_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      M_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & src_a[XLEN-1];
  assign b_neg = b_signed & src_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // lo holds the multiplier (mul) or the dividend draining into the quotient (div).
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_fit   = div_shift >= {1'b0, b_reg};
  assign div_diff  = div_shift[XLEN-1:0] - b_reg;

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          state_next = MD_BUSY;
          busy       = 1'b1;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (cnt_reg == LAST_CNT) state_next = MD_DONE;
      end
      MD_DONE: begin
        done       = 1'b1;
        state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= MD_IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      rd_reg     <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == MD_IDLE && start) begin
        cnt_reg    <= '0;
        hi_reg     <= '0;
        lo_reg     <= a_mag;
        b_reg      <= b_mag;
        op_reg     <= op;
        rd_reg     <= rd;
        a_neg_reg  <= a_neg;
        b_neg_reg  <= b_neg;
        b_zero_reg <= (src_b == '0);
      end else if (state_reg == MD_BUSY) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (is_div_op(op_reg)) begin
          hi_reg <= div_fit ? div_diff : div_shift[XLEN-1:0];
          lo_reg <= {lo_reg[XLEN-2:0], div_fit};
        end else begin
          hi_reg <= mul_sum[XLEN:1];
          lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
        end
      end
    end
  end

  // Divide-by-zero quotient is forced to all-ones; the remainder naturally
  // equals the dividend. Signed overflow falls out of the magnitude path.
  assign prod     = {hi_reg, lo_reg};
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -prod : prod;
  assign quo      = b_zero_reg ? '1 : ((a_neg_reg ^ b_neg_reg) ? -lo_reg : lo_reg);
  assign rem      = a_neg_reg ? -hi_reg : hi_reg;

  always_comb begin
    case (op_reg)
      M_MUL:                     result = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             result = quo;
      default:                   result = rem;
    endcase
  end

  assign result_rd = rd_reg;

endmodule

// File: rtl/execute_stage_m.sv
// RV execute stage with forwarding, ALU/branch/jump, iterative M-extension and
// a registered EX/MEM boundary. Define FAST_MUL_EN for single-cycle MUL* ops.
module execute_stage_m
  import rv_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  execute_stage_m_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_result, ex_pc;
  logic [SHW-1:0]  shamt;
  alu_op_t         alu_op;
  logic            alu_zero, branch_cond, alt_funct7;
  logic            commit, md_start, md_busy, md_done;
  logic [XLEN-1:0] md_result;
  logic [4:0]      md_rd;
  logic            fast_mul;
  logic [XLEN-1:0] fast_result;

  logic            mem_valid_reg, mem_regwrite_reg, mem_memtoreg_reg;
  logic            mem_memwrite_reg, mem_memread_reg;
  logic [XLEN-1:0] mem_alu_result_reg, mem_write_data_reg, ex_result;
  logic [4:0]      mem_rd_reg;
  logic [2:0]      mem_funct3_reg;

  always_comb begin
    case (bus.forward_a)
      FWD_EXMEM: fwd_a = bus.mem_alu_result;
      FWD_MEMWB: fwd_a = bus.wb_alu_result;
      default:   fwd_a = bus.ex_read_data_1;
    endcase
    case (bus.forward_b)
      FWD_EXMEM: fwd_b = bus.mem_alu_result;
      FWD_MEMWB: fwd_b = bus.wb_alu_result;
      default:   fwd_b = bus.ex_read_data_2;
    endcase
  end

  assign ex_pc = bus.ex_pc_plus_4 - XLEN'(4);

  always_comb begin
    case (bus.ex_op_a_sel)
      OPA_PC:   alu_a = ex_pc;
      OPA_ZERO: alu_a = '0;
      default:  alu_a = fwd_a;
    endcase
  end

  assign alu_b = bus.ex_ALUSrc ? bus.ex_immediate : fwd_b;
  assign shamt = alu_b[SHW-1:0];

  // R-type uses the full funct7 for SUB/SRA; I-type SRAI leaves bit 0 to shamt on RV64.
  assign alt_funct7 = (bus.ex_ALUOp == ALUOP_RTYPE) ? (bus.ex_funct7 == 7'b0100000)
                                                    : (bus.ex_funct7[6:1] == 6'b010000);

  always_comb begin
    alu_op = ALU_ADD;
    case (bus.ex_ALUOp)
      ALUOP_BRANCH: begin
        case (bus.ex_funct3[2:1])
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: alu_op = ALU_SUB;
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (bus.ex_funct3)
          3'b000: alu_op = (bus.ex_ALUOp == ALUOP_RTYPE && alt_funct7) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = alt_funct7 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_result = XLEN'(alu_a < alu_b);
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $signed(alu_a) >>> shamt;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = alu_a + alu_b;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  always_comb begin
    case (bus.ex_funct3)
      3'b000:         branch_cond = alu_zero;
      3'b001:         branch_cond = ~alu_zero;
      3'b100, 3'b110: branch_cond = alu_result[0];
      3'b101, 3'b111: branch_cond = ~alu_result[0];
      default:        branch_cond = 1'b0;
    endcase
  end

  assign bus.branch_taken_out = ((bus.ex_Branch & branch_cond) | bus.ex_Jump) &
                                bus.ex_valid & ~md_busy & ~bus.flush;
  assign bus.branch_target_addr_out = bus.ex_Jump ? {alu_result[XLEN-1:1], 1'b0}
                                                  : ex_pc + bus.ex_immediate;

`ifdef FAST_MUL_EN
  logic            fm_a_sx, fm_b_sx;
  logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
  assign fast_mul = bus.ex_muldiv & ~is_div_op(bus.ex_funct3);
  assign fm_a_sx  = (bus.ex_funct3 != M_MULHU) & fwd_a[XLEN-1];
  assign fm_b_sx  = ((bus.ex_funct3 == M_MUL) | (bus.ex_funct3 == M_MULH)) & fwd_b[XLEN-1];
  assign fm_a     = {{XLEN{fm_a_sx}}, fwd_a};
  assign fm_b     = {{XLEN{fm_b_sx}}, fwd_b};
  assign fm_prod  = fm_a * fm_b;
  assign fast_result = (bus.ex_funct3 == M_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul    = 1'b0;
  assign fast_result = '0;
`endif

  assign md_start = bus.ex_valid & bus.ex_muldiv & ~bus.flush & ~fast_mul;

  muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .flush     (bus.flush),
    .op        (bus.ex_funct3),
    .src_a     (fwd_a),
    .src_b     (fwd_b),
    .rd        (bus.ex_rd),
    .busy      (md_busy),
    .done      (md_done),
    .result    (md_result),
    .result_rd (md_rd)
  );

  assign bus.ex_stall = md_busy;
  assign commit       = bus.ex_valid & ~bus.flush;

  always_comb begin
    if (md_done)          ex_result = md_result;
    else if (bus.ex_Jump) ex_result = bus.ex_pc_plus_4;
    else if (fast_mul)    ex_result = fast_result;
    else                  ex_result = alu_result;
  end

  // A stalled cycle loads a bubble so the frozen instruction is not duplicated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_reg      <= 1'b0;
      mem_regwrite_reg   <= 1'b0;
      mem_memtoreg_reg   <= 1'b0;
      mem_memwrite_reg   <= 1'b0;
      mem_memread_reg    <= 1'b0;
      mem_alu_result_reg <= '0;
      mem_write_data_reg <= '0;
      mem_rd_reg         <= '0;
      mem_funct3_reg     <= '0;
    end else if (md_busy) begin
      mem_valid_reg    <= 1'b0;
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      mem_memwrite_reg <= 1'b0;
      mem_memread_reg  <= 1'b0;
    end else begin
      mem_valid_reg      <= commit;
      mem_regwrite_reg   <= commit & bus.ex_RegWrite;
      mem_memtoreg_reg   <= commit & bus.ex_MemtoReg;
      mem_memwrite_reg   <= commit & bus.ex_MemWrite;
      mem_memread_reg    <= commit & bus.ex_MemRead;
      mem_alu_result_reg <= ex_result;
      mem_write_data_reg <= fwd_b;
      mem_rd_reg         <= md_done ? md_rd : bus.ex_rd;
      mem_funct3_reg     <= bus.ex_funct3;
    end
  end

  assign bus.mem_valid_out      = mem_valid_reg;
  assign bus.mem_RegWrite_out   = mem_regwrite_reg;
  assign bus.mem_MemtoReg_out   = mem_memtoreg_reg;
  assign bus.mem_MemWrite_out   = mem_memwrite_reg;
  assign bus.mem_MemRead_out    = mem_memread_reg;
  assign bus.mem_alu_result_out = mem_alu_result_reg;
  assign bus.mem_write_data_out = mem_write_data_reg;
  assign bus.mem_rd_out         = mem_rd_reg;
  assign bus.mem_funct3_out     = mem_funct3_reg;

endmodule

// File: tb/tb_execute_stage_m.sv
// Directed bench for execute_stage_m: ALU/forwarding, M ops and corner cases,
// flush, reset mid-operation, branch/jump redirect gating.
module tb_execute_stage_m;
  import rv_ex_pkg::*;

  localparam int XLEN = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = XLEN + 1;
`endif
  localparam int DIV_STALL = XLEN + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   leaks;

  execute_stage_m_if #(.XLEN(XLEN)) bus ();

  execute_stage_m #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.flush = 0; bus.ex_RegWrite = 0; bus.ex_MemtoReg = 0;
    bus.ex_Branch = 0; bus.ex_Jump = 0; bus.ex_MemRead = 0; bus.ex_MemWrite = 0;
    bus.ex_ALUSrc = 0; bus.ex_muldiv = 0; bus.ex_op_a_sel = OPA_RS1; bus.ex_ALUOp = ALUOP_ADD;
    bus.ex_read_data_1 = '0; bus.ex_read_data_2 = '0; bus.ex_immediate = '0;
    bus.ex_pc_plus_4 = '0; bus.ex_rd = '0; bus.ex_funct3 = '0; bus.ex_funct7 = '0;
    bus.forward_a = FWD_RF; bus.forward_b = FWD_RF;
    bus.mem_alu_result = '0; bus.wb_alu_result = '0;
  endtask

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    bus.ex_valid = 1; bus.ex_muldiv = 1; bus.ex_RegWrite = 1; bus.ex_ALUOp = ALUOP_RTYPE;
    bus.ex_funct7 = 7'b0000001; bus.ex_funct3 = f3; bus.ex_rd = 5'd7;
    bus.ex_read_data_1 = a; bus.ex_read_data_2 = b;
  endtask

  task automatic m_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int stalls = 0;
    int bubble_err = 0;
    drive_m(f3, a, b);
    #1;
    while (bus.ex_stall === 1'b1 && stalls < 200) begin
      step();
      stalls++;
      if (bus.mem_valid_out !== 1'b0) bubble_err++;
    end
    step();
    chk({tag, "_stall"}, stalls, exp_stall);
    chk({tag, "_bubble"}, bubble_err, 0);
    chk({tag, "_valid"}, bus.mem_valid_out, 1);
    chk({tag, "_rd"}, bus.mem_rd_out, 7);
    chk({tag, "_result"}, bus.mem_alu_result_out, exp);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_stall", bus.ex_stall, 0);
    chk("rst_valid", bus.mem_valid_out, 0);
    chk("rst_regwrite", bus.mem_RegWrite_out, 0);
    chk("rst_result", bus.mem_alu_result_out, 0);
    rst = 0;
    step();

    // ADDI with rs1 forwarded from EX/MEM: 10 + 7
    bus.ex_valid = 1; bus.ex_RegWrite = 1; bus.ex_ALUOp = ALUOP_ITYPE; bus.ex_ALUSrc = 1;
    bus.ex_read_data_1 = 5; bus.forward_a = FWD_EXMEM; bus.mem_alu_result = 10;
    bus.ex_immediate = 7; bus.ex_rd = 5'd3;
    #1 chk("add_stall", bus.ex_stall, 0);
    step();
    chk("add_result", bus.mem_alu_result_out, 17);
    chk("add_valid", bus.mem_valid_out, 1);
    chk("add_rd", bus.mem_rd_out, 3);
    chk("add_regwrite", bus.mem_RegWrite_out, 1);

    // SUB with rs2 forwarded from MEM/WB: 50 - 8
    idle_inputs();
    bus.ex_valid = 1; bus.ex_RegWrite = 1; bus.ex_ALUOp = ALUOP_RTYPE; bus.ex_funct7 = 7'b0100000;
    bus.ex_read_data_1 = 50; bus.ex_read_data_2 = 999; bus.forward_b = FWD_MEMWB; bus.wb_alu_result = 8;
    step();
    chk("sub_result", bus.mem_alu_result_out, 42);

    // SRA 0x80000000 >>> 4
    idle_inputs();
    bus.ex_valid = 1; bus.ex_ALUOp = ALUOP_RTYPE; bus.ex_funct3 = 3'b101; bus.ex_funct7 = 7'b0100000;
    bus.ex_read_data_1 = 32'h8000_0000; bus.ex_read_data_2 = 4;
    step();
    chk("sra_result", bus.mem_alu_result_out, 32'hF800_0000);

    // SW: address 0x100+8, store data forwarded from MEM/WB
    idle_inputs();
    bus.ex_valid = 1; bus.ex_MemWrite = 1; bus.ex_ALUSrc = 1; bus.ex_funct3 = 3'b010;
    bus.ex_read_data_1 = 32'h100; bus.ex_immediate = 8; bus.forward_b = FWD_MEMWB; bus.wb_alu_result = 32'hABCD;
    step();
    chk("sw_addr", bus.mem_alu_result_out, 32'h108);
    chk("sw_data", bus.mem_write_data_out, 32'hABCD);
    chk("sw_memwrite", bus.mem_MemWrite_out, 1);
    chk("sw_funct3", bus.mem_funct3_out, 2);

    // AUIPC (A=PC) and LUI (A=zero)
    idle_inputs();
    bus.ex_valid = 1; bus.ex_ALUSrc = 1; bus.ex_op_a_sel = OPA_PC;
    bus.ex_pc_plus_4 = 32'h1004; bus.ex_immediate = 32'h2000;
    step();
    chk("auipc_result", bus.mem_alu_result_out, 32'h3000);
    bus.ex_op_a_sel = OPA_ZERO; bus.ex_read_data_1 = 32'h77; bus.ex_immediate = 32'h5000;
    step();
    chk("lui_result", bus.mem_alu_result_out, 32'h5000);

    // M-extension
    m_op("mul",    M_MUL,    32'hFFFF_FFFF, 3, 32'hFFFF_FFFD, MUL_STALL);
    m_op("mulh",   M_MULH,   32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, MUL_STALL);
    m_op("mulhu",  M_MULHU,  32'hFFFF_FFFF, 3, 32'h0000_0002, MUL_STALL);
    m_op("mulhsu", M_MULHSU, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, MUL_STALL);
    m_op("div_by0", M_DIV, 7, 0, 32'hFFFF_FFFF, DIV_STALL);
    m_op("rem_by0", M_REM, 7, 0, 7, DIV_STALL);
    m_op("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALL);
    m_op("rem_ovf", M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, DIV_STALL);
    m_op("divu", M_DIVU, 100, 7, 14, DIV_STALL);
    m_op("remu", M_REMU, 100, 7, 2, DIV_STALL);
    m_op("div_neg", M_DIV, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, DIV_STALL);
    m_op("rem_neg", M_REM, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, DIV_STALL);

    // Flush on BUSY cycle 10
    drive_m(M_DIVU, 100, 7);
    step();
    repeat (9) step();
    chk("flush_busy", bus.ex_stall, 1);
    bus.flush = 1;
    step();
    idle_inputs();
    #1;
    chk("flush_stall", bus.ex_stall, 0);
    chk("flush_valid", bus.mem_valid_out, 0);
    leaks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.mem_valid_out !== 1'b0) leaks++;
    end
    chk("flush_no_write", leaks, 0);
    bus.ex_valid = 1; bus.ex_RegWrite = 1; bus.ex_ALUOp = ALUOP_RTYPE;
    bus.ex_read_data_1 = 20; bus.ex_read_data_2 = 22;
    step();
    chk("post_flush_add", bus.mem_alu_result_out, 42);
    chk("post_flush_valid", bus.mem_valid_out, 1);

    // Asynchronous reset in the middle of a divide
    drive_m(M_DIV, 100, 7);
    repeat (5) step();
    idle_inputs();
    rst = 1;
    #1;
    chk("midop_rst_stall", bus.ex_stall, 0);
    chk("midop_rst_result", bus.mem_alu_result_out, 0);
    @(negedge clk);
    rst = 0;
    step();

    // JALR
    idle_inputs();
    bus.ex_valid = 1; bus.ex_Jump = 1; bus.ex_RegWrite = 1; bus.ex_ALUSrc = 1;
    bus.ex_read_data_1 = 32'h1001; bus.ex_immediate = 4; bus.ex_pc_plus_4 = 32'h208;
    #1;
    chk("jalr_target", bus.branch_target_addr_out, 32'h1004);
    chk("jalr_taken", bus.branch_taken_out, 1);
    step();
    chk("jalr_link", bus.mem_alu_result_out, 32'h208);

    // Branches
    idle_inputs();
    bus.ex_valid = 1; bus.ex_Branch = 1; bus.ex_ALUOp = ALUOP_BRANCH;
    bus.ex_read_data_1 = 9; bus.ex_read_data_2 = 9; bus.ex_pc_plus_4 = 32'h104; bus.ex_immediate = 32'h20;
    #1;
    chk("beq_target", bus.branch_target_addr_out, 32'h120);
    chk("beq_taken", bus.branch_taken_out, 1);
    bus.ex_funct3 = 3'b001;
    #1 chk("bne_taken", bus.branch_taken_out, 0);
    bus.ex_read_data_1 = 32'hFFFF_FFFF; bus.ex_read_data_2 = 1; bus.ex_funct3 = 3'b100;
    #1 chk("blt_taken", bus.branch_taken_out, 1);
    bus.ex_funct3 = 3'b110;
    #1 chk("bltu_taken", bus.branch_taken_out, 0);
    bus.ex_read_data_1 = 9; bus.ex_read_data_2 = 9; bus.ex_funct3 = 3'b000; bus.flush = 1;
    #1 chk("beq_flush_taken", bus.branch_taken_out, 0);
    step();
    chk("beq_flush_valid", bus.mem_valid_out, 0);

    // BEQ presented while the divider holds the stall
    drive_m(M_DIV, 100, 7);
    step();
    bus.ex_muldiv = 0; bus.ex_RegWrite = 0; bus.ex_Branch = 1; bus.ex_ALUOp = ALUOP_BRANCH;
    bus.ex_funct3 = 3'b000; bus.ex_funct7 = '0;
    bus.ex_read_data_1 = 9; bus.ex_read_data_2 = 9;
    #1;
    chk("beq_stall_stall", bus.ex_stall, 1);
    chk("beq_stall_taken", bus.branch_taken_out, 0);
    bus.flush = 1;
    step();
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
